// File: rtl/comb_diff_if.sv
// Stream-side signals of comb_diff: input sample handshake, output difference handshake,
// fill restart and primed status. The design uses slave; the driving side uses master.
interface comb_diff_if #(
  parameter int DATA_WIDTH = 32
);
  logic                         clear_in;
  logic signed [DATA_WIDTH-1:0] data_in;
  logic                         data_in_valid;
  logic                         data_in_ready;
  logic signed [DATA_WIDTH-1:0] data_out;
  logic                         data_out_valid;
  logic                         data_out_ready;
  logic                         primed_out;

  modport master (
    output clear_in, data_in, data_in_valid, data_out_ready,
    input  data_in_ready, data_out, data_out_valid, primed_out
  );

  modport slave (
    input  clear_in, data_in, data_in_valid, data_out_ready,
    output data_in_ready, data_out, data_out_valid, primed_out
  );
endinterface

// File: rtl/comb_diff.sv
// Delay-line differencer y[n] = x[n] - x[n-2^DELAY_SHIFT], one registered output stage, ready/valid both sides.
// COMB_DIFF_SAT_EN selects a saturating difference; otherwise the difference wraps to DATA_WIDTH bits.
module comb_diff #(
  parameter int DATA_WIDTH  = 32,
  parameter int DELAY_SHIFT = 4
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  comb_diff_if.slave  io
);
  localparam int D = 1 << DELAY_SHIFT;
  localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic {FILL = 1'b0, RUN = 1'b1} state_t;

  state_t                       state_q, state_d;
  logic [DELAY_SHIFT-1:0]       addr_q, addr_d;
  logic signed [DATA_WIDTH-1:0] dline [D];
  logic signed [DATA_WIDTH-1:0] old_sample;
  logic signed [DATA_WIDTH-1:0] result;
  logic signed [DATA_WIDTH-1:0] out_q;
  logic signed [DATA_WIDTH:0]   diff;
  logic                         out_vld_q;
  logic                         accept;

  assign io.data_in_ready  = !io.clear_in && (!out_vld_q || io.data_out_ready);
  assign accept            = io.data_in_valid && io.data_in_ready;
  assign io.data_out       = out_q;
  assign io.data_out_valid = out_vld_q;
  assign io.primed_out     = (state_q == RUN);

  // Read-before-write: the slot about to be overwritten holds x[n-D].
  assign old_sample = dline[addr_q];
  assign diff = {io.data_in[DATA_WIDTH-1], io.data_in} - {old_sample[DATA_WIDTH-1], old_sample};

`ifdef COMB_DIFF_SAT_EN
  always_comb begin
    result = diff[DATA_WIDTH-1:0];
    if (diff[DATA_WIDTH] != diff[DATA_WIDTH-1]) begin
      result = diff[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
    end
  end
`else
  assign result = diff[DATA_WIDTH-1:0];
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    if (io.clear_in) begin
      state_d = FILL;
      addr_d  = '0;
    end else if (accept) begin
      addr_d = addr_q + DELAY_SHIFT'(1);
      if (state_q == FILL && (&addr_q)) begin
        state_d = RUN;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= FILL;
      addr_q    <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      if (io.clear_in) begin
        out_vld_q <= 1'b0;
      end else if (accept && state_q == RUN) begin
        out_q     <= result;
        out_vld_q <= 1'b1;
      end else if (out_vld_q && io.data_out_ready) begin
        out_vld_q <= 1'b0;
      end
    end
  end

  // Delay line is never reset; FILL overwrites every slot before it is read.
  always_ff @(posedge clk_in) begin
    if (accept) begin
      dline[addr_q] <= io.data_in;
    end
  end
endmodule
